vdc_crtc_timing: RTL and testbench
==================================

# vdc_crtc_timing

CRT controller timing generator for the 8563/8568 VDC, directly downstream of the VDC register file. It turns the programmed geometry (R0–R9, R22, R37) into character/scanline/row counters, sync pulses, display-enable and frame-count outputs. The fetch and pixel-shift stages consume these outputs. It advances only on pixel-enable cycles, so double-width mode is handled entirely by the enable that is fed in.

## Interface
Parameters:
- none; all widths are fixed by the VDC register map.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  pixel enable, already qualified by double-width mode; counters advance only when high
- reg_ht  in  8  R0, horizontal total in characters minus 1
- reg_hd  in  8  R1, horizontal displayed characters
- reg_hp  in  8  R2, hsync start column
- reg_hw  in  4  R3[3:0], hsync width in characters; 0 means 16
- reg_vt  in  8  R4, vertical total in rows minus 1
- reg_va  in  5  R5, vertical adjust in scanlines
- reg_vd  in  8  R6, vertical displayed rows
- reg_vp  in  8  R7, vsync start row
- reg_vw  in  4  R3[7:4], vsync width in scanlines; 0 means 16
- reg_ctv  in  5  R9, scanlines per row minus 1
- reg_cth  in  4  R22[7:4], pixels per character minus 1
- reg_hspol, reg_vspol  in  1  R37 sync polarity; 1 = active-high; tied 1 on 8563
- col  out  8  current character column
- row  out  8  current character row; holds reg_vt during adjust
- line  out  5  scanline within row, or within adjust
- pix  out  4  pixel within character
- hsync, vsync  out  1  polarity-applied sync
- de  out  1  display enable (hde & vde)
- vadj  out  1  vertical-adjust phase active
- line_start, row_start, frame_start  out  1  one-clk strobes
- fcnt  out  5  frame counter, used for blink (bit 3 = 1/16, bit 4 = 1/32)

## Operation
- The counters form a cascade. Each stage wraps on an equality compare against its limit; nothing happens at a terminal value other than the wrap.
  - pix counts 0..reg_cth. Its wrap is the char tick.
  - col counts 0..reg_ht on each char tick. Its wrap is the line tick.
  - line counts 0..reg_ctv on each line tick. Its wrap is the row tick.
  - row counts 0..reg_vt on each row tick.
- At the row tick that ends row reg_vt:
  - if reg_va ≠ 0: enter adjust (vadj=1, line=0); adjust lasts reg_va scanlines, then the frame tick.
  - if reg_va = 0: the frame tick happens immediately.
- Frame tick: row=0, line=0, vadj=0, fcnt+1 (mod 32).
- Limit lowered below the live count: the counter runs on to its 8-bit/5-bit/4-bit natural wrap, then resumes normally. This is 6845-family runaway and is required behaviour.
- Horizontal sync: hs_act is set at the char tick entering col == reg_hp. It stays set for reg_hw characters, counted in an internal 4-bit counter (0 counts as 16). The window may cross the col wrap.
- Vertical sync: vs_act is set at the line tick entering line 0 of row reg_vp (never during adjust). It stays set for reg_vw scanlines (0 counts as 16). It may cross the frame wrap.
- Polarity: hsync = hs_act when reg_hspol=1, else ~hs_act. vsync is built the same way from vs_act and reg_vspol.
- Display enable:
  - hde = (col < reg_hd)
  - vde = !vadj && (row < reg_vd)
  - de = hde & vde
- Simultaneous sync retrigger: if a sync start condition recurs while that sync is still active, its width counter restarts.

## Timing
- All outputs are registered and updated on the clk edge of an enable cycle. Between enable cycles, everything except the strobes holds.
- Strobes last exactly one clk, on the edge where the corresponding wrap occurs.
  - line_start and row_start coincide on a row wrap.
  - All three strobes coincide on a frame wrap.
- Latency: zero enable cycles between a counter value and its decoded outputs (de, hs_act and vs_act are computed from next-state values).
- Register changes take effect at the next compare; there is no shadowing.
- Reset state (asynchronous, on assertion): all counters 0, fcnt=0, hs_act=vs_act=0, vadj=0, strobes 0, de=0. After release, pin levels are hsync=~reg_hspol and vsync=~reg_vspol.
- Reset asserted mid-frame: immediate return to the reset state. The first enable after release produces pix=1 with no strobe.

## Structure
- vdc_pkg holds:
  - the sync-width zero-means-16 helper
  - field width localparams: COL_W=8, LINE_W=5, PIX_W=4
- One natural sub-module: vdc_wrap_counter, a parameterised-width counter with tick-in, limit, equality wrap and tick-out. It is instantiated four times.

## Test plan
- Horizontal cadence. Stimulus: enable constant 1, reg_cth=1, reg_ht=9, reg_hd=6. Required: line_start every 20 clk; de high for 12 clk of each 20.
- Hsync. Stimulus: reg_hp=7, reg_hw=2, polarity 1. Required: hsync high for cols 7–8 (4 clk); with reg_hw=0 and reg_ht=31, hsync is high for 16 characters.
- Vertical frame with adjust. Stimulus: reg_ctv=7, reg_vt=3, reg_va=3. Required: vadj high for 3 lines after row 3; frame_start every 35 lines. With reg_va=0: frame_start every 32 lines.
- Vsync and polarity. Stimulus: reg_vp=2, reg_vw=4, reg_vspol=0. Required: vsync low for lines 16–19 of the frame; fcnt[3] toggles every 8 frames.
- Runaway. Stimulus: reg_ht changed from 20 to 5 while col=12. Required: col counts to 255, wraps to 0, then cycles 0..5.
- Async reset mid-frame. Stimulus: reset_n pulsed low without a clk edge. Required: all outputs at reset values immediately; de=0, line_start=0.

Source files
------------

// File: rtl/vdc_pkg.sv
// Shared widths and helpers for the 8563/8568 VDC CRT timing generator.
package vdc_pkg;

  localparam int COL_W  = 8;
  localparam int ROW_W  = 8;
  localparam int LINE_W = 5;
  localparam int PIX_W  = 4;
  localparam int SYNC_W = 4;
  localparam int FCNT_W = 5;

  // Sync width fields encode 16 as 0; return the real width in characters/scanlines.
  function automatic logic [SYNC_W:0] sync_width(input logic [SYNC_W-1:0] w);
    logic [SYNC_W:0] r;
    if (w == 4'd0) begin
      r = 5'd16;
    end else begin
      r = {1'b0, w};
    end
    return r;
  endfunction

endpackage

// File: rtl/vdc_crtc_timing_if.sv
// Geometry inputs and timing outputs of the CRTC, grouped as one bundle.
interface vdc_crtc_timing_if
  import vdc_pkg::*;
;
  logic              enable;
  logic [7:0]        reg_ht;
  logic [7:0]        reg_hd;
  logic [7:0]        reg_hp;
  logic [3:0]        reg_hw;
  logic [7:0]        reg_vt;
  logic [4:0]        reg_va;
  logic [7:0]        reg_vd;
  logic [7:0]        reg_vp;
  logic [3:0]        reg_vw;
  logic [4:0]        reg_ctv;
  logic [3:0]        reg_cth;
  logic              reg_hspol;
  logic              reg_vspol;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [LINE_W-1:0] line;
  logic [PIX_W-1:0]  pix;
  logic              hsync;
  logic              vsync;
  logic              de;
  logic              vadj;
  logic              line_start;
  logic              row_start;
  logic              frame_start;
  logic [FCNT_W-1:0] fcnt;

  // Register file / enable source side.
  modport master (
    output enable, reg_ht, reg_hd, reg_hp, reg_hw, reg_vt, reg_va, reg_vd,
           reg_vp, reg_vw, reg_ctv, reg_cth, reg_hspol, reg_vspol,
    input  col, row, line, pix, hsync, vsync, de, vadj,
           line_start, row_start, frame_start, fcnt
  );

  // Timing generator side.
  modport slave (
    input  enable, reg_ht, reg_hd, reg_hp, reg_hw, reg_vt, reg_va, reg_vd,
           reg_vp, reg_vw, reg_ctv, reg_cth, reg_hspol, reg_vspol,
    output col, row, line, pix, hsync, vsync, de, vadj,
           line_start, row_start, frame_start, fcnt
  );

endinterface

// File: rtl/vdc_wrap_counter.sv
// One stage of the CRTC counter cascade: advances on tick_i, wraps to 0 on an
// equality match with limit_i (or holds there when hold_i), and otherwise runs
// to its natural binary wrap, which gives 6845-style runaway when the limit is
// lowered below the live count.
module vdc_wrap_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         tick_i,
  input  logic [W-1:0] limit_i,
  input  logic         hold_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] next_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap_o = tick_i && (cnt_q == limit_i);
  assign cnt_o  = cnt_q;
  assign next_o = cnt_d;

  // Next count: forced clear, wrap (or hold at limit), increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (wrap_o) begin
      if (hold_i) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = '0;
      end
    end else if (tick_i) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vdc_crtc_timing.sv
// VDC CRTC timing generator: pix/col/line/row cascade, vertical adjust,
// sync windows, display enable, strobes and blink frame counter. Everything
// advances only on enable cycles; decodes use next-state counter values so
// outputs line up with the counters with no extra latency.
module vdc_crtc_timing
  import vdc_pkg::*;
(
  input logic               clk,
  input logic               reset_n,
  vdc_crtc_timing_if.slave  bus
);

  logic [PIX_W-1:0]  pix_cnt_s;
  logic [PIX_W-1:0]  unused_pix_next_s;
  logic              pix_wrap_s;
  logic [COL_W-1:0]  col_cnt_s;
  logic [COL_W-1:0]  col_next_s;
  logic              col_wrap_s;
  logic [LINE_W-1:0] line_cnt_s;
  logic [LINE_W-1:0] line_next_s;
  logic [LINE_W-1:0] line_limit_s;
  logic              line_wrap_s;
  logic [ROW_W-1:0]  row_cnt_s;
  logic [ROW_W-1:0]  row_next_s;
  logic              row_wrap_s;
  logic              row_tick_s;
  logic              va_nz_s;
  logic              frame_tick_s;
  logic              vs_start_s;

  logic              vadj_q, vadj_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              hs_act_q, hs_act_d;
  logic [SYNC_W-1:0] hs_cnt_q, hs_cnt_d;
  logic              vs_act_q, vs_act_d;
  logic [SYNC_W-1:0] vs_cnt_q, vs_cnt_d;
  logic              de_q, de_d;
  logic              line_start_q;
  logic              row_start_q;
  logic              frame_start_q;

  // Pixel within character; its wrap is the char tick.
  vdc_wrap_counter #(.W(PIX_W)) u_pix (
    .clk     (clk),
    .reset_n (reset_n),
    .tick_i  (bus.enable),
    .limit_i (bus.reg_cth),
    .hold_i  (1'b0),
    .clr_i   (1'b0),
    .cnt_o   (pix_cnt_s),
    .next_o  (unused_pix_next_s),
    .wrap_o  (pix_wrap_s)
  );

  // Character column; its wrap is the line tick.
  vdc_wrap_counter #(.W(COL_W)) u_col (
    .clk     (clk),
    .reset_n (reset_n),
    .tick_i  (pix_wrap_s),
    .limit_i (bus.reg_ht),
    .hold_i  (1'b0),
    .clr_i   (1'b0),
    .cnt_o   (col_cnt_s),
    .next_o  (col_next_s),
    .wrap_o  (col_wrap_s)
  );

  // Scanline within a row, or within the adjust band.
  vdc_wrap_counter #(.W(LINE_W)) u_line (
    .clk     (clk),
    .reset_n (reset_n),
    .tick_i  (col_wrap_s),
    .limit_i (line_limit_s),
    .hold_i  (1'b0),
    .clr_i   (1'b0),
    .cnt_o   (line_cnt_s),
    .next_o  (line_next_s),
    .wrap_o  (line_wrap_s)
  );

  // Character row; parks on reg_vt through adjust and is cleared by the frame tick.
  vdc_wrap_counter #(.W(ROW_W)) u_row (
    .clk     (clk),
    .reset_n (reset_n),
    .tick_i  (row_tick_s),
    .limit_i (bus.reg_vt),
    .hold_i  (va_nz_s),
    .clr_i   (frame_tick_s),
    .cnt_o   (row_cnt_s),
    .next_o  (row_next_s),
    .wrap_o  (row_wrap_s)
  );

  assign va_nz_s      = (bus.reg_va != 5'd0);
  assign row_tick_s   = line_wrap_s && !vadj_q;
  assign frame_tick_s = (row_wrap_s && !va_nz_s) || (vadj_q && line_wrap_s);

  // Line limit: scanlines per row normally, adjust length during adjust.
  always_comb begin
    if (vadj_q) begin
      line_limit_s = bus.reg_va - 5'd1;
    end else begin
      line_limit_s = bus.reg_ctv;
    end
  end

  // Vertical adjust phase and frame counter.
  always_comb begin
    vadj_d = vadj_q;
    fcnt_d = fcnt_q;
    if (frame_tick_s) begin
      vadj_d = 1'b0;
      fcnt_d = fcnt_q + 5'd1;
    end else if (row_wrap_s && va_nz_s) begin
      vadj_d = 1'b1;
    end else begin
      vadj_d = vadj_q;
    end
  end

  // Hsync window: starts entering col reg_hp, lasts reg_hw characters; a new start restarts it.
  always_comb begin
    hs_act_d = hs_act_q;
    hs_cnt_d = hs_cnt_q;
    if (pix_wrap_s) begin
      if (col_next_s == bus.reg_hp) begin
        hs_act_d = 1'b1;
        hs_cnt_d = 4'd0;
      end else if (hs_act_q) begin
        if (({1'b0, hs_cnt_q} + 5'd1) == sync_width(bus.reg_hw)) begin
          hs_act_d = 1'b0;
          hs_cnt_d = 4'd0;
        end else begin
          hs_cnt_d = hs_cnt_q + 4'd1;
        end
      end else begin
        hs_act_d = hs_act_q;
      end
    end else begin
      hs_act_d = hs_act_q;
    end
  end

  assign vs_start_s = (line_next_s == 5'd0) && (row_next_s == bus.reg_vp) && !vadj_d;

  // Vsync window: starts entering line 0 of row reg_vp, lasts reg_vw scanlines.
  always_comb begin
    vs_act_d = vs_act_q;
    vs_cnt_d = vs_cnt_q;
    if (col_wrap_s) begin
      if (vs_start_s) begin
        vs_act_d = 1'b1;
        vs_cnt_d = 4'd0;
      end else if (vs_act_q) begin
        if (({1'b0, vs_cnt_q} + 5'd1) == sync_width(bus.reg_vw)) begin
          vs_act_d = 1'b0;
          vs_cnt_d = 4'd0;
        end else begin
          vs_cnt_d = vs_cnt_q + 4'd1;
        end
      end else begin
        vs_act_d = vs_act_q;
      end
    end else begin
      vs_act_d = vs_act_q;
    end
  end

  // Display enable from the next-state position.
  always_comb begin
    if (bus.enable) begin
      de_d = (col_next_s < bus.reg_hd) && !vadj_d && (row_next_s < bus.reg_vd);
    end else begin
      de_d = de_q;
    end
  end

  // Phase, sync, enable and strobe registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vadj_q        <= 1'b0;
      fcnt_q        <= 5'd0;
      hs_act_q      <= 1'b0;
      hs_cnt_q      <= 4'd0;
      vs_act_q      <= 1'b0;
      vs_cnt_q      <= 4'd0;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      row_start_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      vadj_q        <= vadj_d;
      fcnt_q        <= fcnt_d;
      hs_act_q      <= hs_act_d;
      hs_cnt_q      <= hs_cnt_d;
      vs_act_q      <= vs_act_d;
      vs_cnt_q      <= vs_cnt_d;
      de_q          <= de_d;
      line_start_q  <= col_wrap_s;
      row_start_q   <= line_wrap_s;
      frame_start_q <= frame_tick_s;
    end
  end

  assign bus.pix         = pix_cnt_s;
  assign bus.col         = col_cnt_s;
  assign bus.line        = line_cnt_s;
  assign bus.row         = row_cnt_s;
  assign bus.vadj        = vadj_q;
  assign bus.fcnt        = fcnt_q;
  assign bus.de          = de_q;
  assign bus.line_start  = line_start_q;
  assign bus.row_start   = row_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.hsync       = bus.reg_hspol ? hs_act_q : ~hs_act_q;
  assign bus.vsync       = bus.reg_vspol ? vs_act_q : ~vs_act_q;

endmodule

// File: tb/tb_vdc_crtc_timing.sv
// Scoreboard bench for vdc_crtc_timing. The reference model derives every
// output from the number of enable cycles since reset using frame arithmetic.
module tb_vdc_crtc_timing;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  vdc_crtc_timing_if bus ();

  vdc_crtc_timing dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int pix; int col; int row; int line; int fcnt;
    bit hs; bit vs; bit de; bit vadj; bit ls; bit rs; bit fs;
    bit full;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  int c_ht, c_hd, c_hp, c_hw, c_vt, c_va, c_vd, c_vp, c_vw, c_ctv, c_cth, c_hpol, c_vpol;

  function automatic void chk(string name, int act, int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  task automatic drive_cfg();
    bus.reg_ht    = 8'(c_ht);
    bus.reg_hd    = 8'(c_hd);
    bus.reg_hp    = 8'(c_hp);
    bus.reg_hw    = 4'(c_hw);
    bus.reg_vt    = 8'(c_vt);
    bus.reg_va    = 5'(c_va);
    bus.reg_vd    = 8'(c_vd);
    bus.reg_vp    = 8'(c_vp);
    bus.reg_vw    = 4'(c_vw);
    bus.reg_ctv   = 5'(c_ctv);
    bus.reg_cth   = 4'(c_cth);
    bus.reg_hspol = c_hpol[0];
    bus.reg_vspol = c_vpol[0];
  endtask

  // Expected outputs after k enable cycles since reset release.
  function automatic exp_t model(int k);
    exp_t e;
    int p, h, ll, rl, nr, f, c, lnum, lf, d, s, hw_w, vw_w, s0;
    bit hs_act, vs_act;
    e = '{default: 0};
    p = c_cth + 1;  h = c_ht + 1;  ll = p * h;
    rl = c_ctv + 1; nr = (c_vt + 1) * rl; f = nr + c_va;
    hw_w = (c_hw == 0) ? 16 : c_hw;
    vw_w = (c_vw == 0) ? 16 : c_vw;
    e.full = 1'b1;
    e.pix  = k % p;
    c      = k / p;
    e.col  = c % h;
    lnum   = k / ll;
    lf     = lnum % f;
    e.fcnt = (lnum / f) % 32;
    if (lf < nr) begin
      e.vadj = 1'b0; e.row = lf / rl; e.line = lf % rl;
    end else begin
      e.vadj = 1'b1; e.row = c_vt; e.line = lf - nr;
    end
    d = ((c - c_hp) % h + h) % h;
    s = c - d;
    hs_act = (s >= 1) && (d < hw_w);
    s0 = c_vp * rl;
    d = ((lnum - s0) % f + f) % f;
    s = lnum - d;
    vs_act = (s >= 1) && (d < vw_w);
    e.hs = hs_act ^ (c_hpol == 0);
    e.vs = vs_act ^ (c_vpol == 0);
    e.de = (k > 0) && (e.col < c_hd) && !e.vadj && (e.row < c_vd);
    e.ls = (k > 0) && (k % ll == 0);
    e.rs = e.ls && ((lf < nr) ? (e.line == 0) : (lf == nr));
    e.fs = e.ls && (lf == 0);
    return e;
  endfunction

  // Monitor: compares the DUT against the next scoreboard entry each cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("col", int'(bus.col), e.col);
      if (e.full) begin
        chk("pix", int'(bus.pix), e.pix);
        chk("row", int'(bus.row), e.row);
        chk("line", int'(bus.line), e.line);
        chk("fcnt", int'(bus.fcnt), e.fcnt);
        chk("vadj", int'(bus.vadj), int'(e.vadj));
        chk("de", int'(bus.de), int'(e.de));
        chk("hsync", int'(bus.hsync), int'(e.hs));
        chk("vsync", int'(bus.vsync), int'(e.vs));
        chk("line_start", int'(bus.line_start), int'(e.ls));
        chk("row_start", int'(bus.row_start), int'(e.rs));
        chk("frame_start", int'(bus.frame_start), int'(e.fs));
      end
    end
  end

  task automatic run_phase(int cycles, int en_pct);
    int k = 0;
    exp_t e;
    for (int i = 0; i < cycles; i++) begin
      bit en;
      en = (int'($urandom_range(99)) < en_pct);
      bus.enable = en;
      @(posedge clk);
      if (en) k++;
      e = model(k);
      if (!en) begin
        e.ls = 1'b0; e.rs = 1'b0; e.fs = 1'b0;
      end
      q.push_back(e);
      #1;
    end
    bus.enable = 1'b0;
  endtask

  task automatic col_step(int v);
    exp_t e;
    e = '{default: 0};
    e.col = v;
    bus.enable = 1'b1;
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  // Lower reg_ht from 20 to 5 while col is 12: col must run away to 255 first.
  task automatic run_runaway();
    for (int i = 1; i <= 12; i++) col_step(i);
    bus.reg_ht = 8'd5;
    for (int v = 13; v <= 255; v++) col_step(v);
    for (int r = 0; r < 3; r++)
      for (int v = 0; v <= 5; v++) col_step(v);
    bus.enable = 1'b0;
  endtask

  task automatic reset_check(string tag);
    chk({tag, "_pix"}, int'(bus.pix), 0);
    chk({tag, "_col"}, int'(bus.col), 0);
    chk({tag, "_row"}, int'(bus.row), 0);
    chk({tag, "_line"}, int'(bus.line), 0);
    chk({tag, "_fcnt"}, int'(bus.fcnt), 0);
    chk({tag, "_vadj"}, int'(bus.vadj), 0);
    chk({tag, "_de"}, int'(bus.de), 0);
    chk({tag, "_line_start"}, int'(bus.line_start), 0);
    chk({tag, "_row_start"}, int'(bus.row_start), 0);
    chk({tag, "_frame_start"}, int'(bus.frame_start), 0);
    chk({tag, "_hsync"}, int'(bus.hsync), (c_hpol == 0) ? 1 : 0);
    chk({tag, "_vsync"}, int'(bus.vsync), (c_vpol == 0) ? 1 : 0);
  endtask

  // Assert reset between clock edges and check outputs return immediately.
  task automatic mid_reset();
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1 reset_check("rst");
  endtask

  // Load the new geometry while in reset, check pin levels, then release.
  task automatic load_release();
    drive_cfg();
    #1;
    chk("rst_hsync_pol", int'(bus.hsync), (c_hpol == 0) ? 1 : 0);
    chk("rst_vsync_pol", int'(bus.vsync), (c_vpol == 0) ? 1 : 0);
    #1 reset_n = 1'b1;
  endtask

  task automatic rand_cfg();
    int w, f, lim;
    c_cth  = int'($urandom_range(0, 2));
    c_ht   = int'($urandom_range(3, 15));
    c_hd   = int'($urandom_range(0, c_ht + 2));
    c_hp   = int'($urandom_range(0, c_ht));
    lim    = (c_ht + 1 < 16) ? c_ht + 1 : 16;
    w      = int'($urandom_range(1, lim));
    c_hw   = w % 16;
    c_ctv  = int'($urandom_range(0, 5));
    c_vt   = int'($urandom_range(1, 5));
    c_va   = int'($urandom_range(0, 4));
    c_vd   = int'($urandom_range(0, c_vt + 2));
    c_vp   = int'($urandom_range(0, c_vt));
    f      = (c_vt + 1) * (c_ctv + 1) + c_va;
    lim    = (f < 16) ? f : 16;
    w      = int'($urandom_range(1, lim));
    c_vw   = w % 16;
    c_hpol = int'($urandom_range(0, 1));
    c_vpol = int'($urandom_range(0, 1));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    bus.enable = 1'b0;
    // Horizontal cadence, hsync cols 7-8, adjust frame, vsync polarity.
    c_cth = 1; c_ht = 9; c_hd = 6; c_hp = 7; c_hw = 2;
    c_ctv = 7; c_vt = 3; c_va = 3; c_vd = 2; c_vp = 2; c_vw = 4;
    c_hpol = 1; c_vpol = 0;
    drive_cfg();
    @(negedge clk);
    #1 reset_check("por");
    #2 reset_n = 1'b1;
    run_phase(6000, 100);

    // Same frame without adjust: 32 lines per frame.
    mid_reset();
    c_va = 0;
    load_release();
    run_phase(2000, 100);

    // 16-character hsync (reg_hw=0), 16-line vsync, gapped enable.
    mid_reset();
    c_cth = 0; c_ht = 31; c_hd = 20; c_hp = 4; c_hw = 0;
    c_ctv = 3; c_vt = 5; c_va = 0; c_vd = 4; c_vp = 5; c_vw = 0;
    c_hpol = 1; c_vpol = 1;
    load_release();
    run_phase(3000, 70);

    // Runaway after lowering the horizontal total.
    mid_reset();
    c_cth = 0; c_ht = 20; c_hd = 10; c_hp = 3; c_hw = 2;
    c_ctv = 3; c_vt = 3; c_va = 0; c_vd = 2; c_vp = 1; c_vw = 2;
    c_hpol = 0; c_vpol = 1;
    load_release();
    run_runaway();

    // Randomised geometries with random enable gaps.
    for (int r = 0; r < 3; r++) begin
      mid_reset();
      rand_cfg();
      load_release();
      run_phase(3000, 80);
    end

    mid_reset();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
